// File: rtl/instr_loader_pkg.sv
// Shared state encoding and default geometry for the program-load buffer.
// The cpu fetch stage reuses the default width/depth constants.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/instr_loader_mem.sv
// DEPTH x WIDTH register array: synchronous write, combinational read, zeroed on reset.
// Zeroing on reset keeps the read port at 0 until something is loaded.
module instr_loader_mem
  import instr_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_loader.sv
// Program-load buffer: host loads instructions, then replays them to the core over valid/ready.
// Optional INSTR_LOADER_LOOP_EN: replay loops forever until clear and exposes loop_cnt.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             clear,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [WIDTH-1:0] issue_instr,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             overflow
`ifdef INSTR_LOADER_LOOP_EN
  ,
  output logic [15:0]      loop_cnt
`endif
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
`ifdef INSTR_LOADER_LOOP_EN
  logic [15:0]      r_loop_cnt;
`endif

  logic             w_load_wr;
  logic             w_last;
  logic             w_fire;
  logic [WIDTH-1:0] w_rdata;

  // A write is accepted in LOAD even when start arrives in the same cycle.
  assign w_load_wr = (r_state == LOAD) && wr_en && (r_count != FULL);
  assign w_last    = (CW'(r_rd_ptr) == (r_count - CW'(1)));
  assign w_fire    = r_valid && issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef INSTR_LOADER_LOOP_EN
      r_loop_cnt <= '0;
`endif
    end else if (clear) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef INSTR_LOADER_LOOP_EN
      r_loop_cnt <= '0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          if (wr_en) begin
            if (r_count != FULL) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          if (start && ((r_count != '0) || w_load_wr)) begin
            r_state  <= RUN;
            r_rd_ptr <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (w_fire) begin
            if (w_last) begin
`ifdef INSTR_LOADER_LOOP_EN
              r_rd_ptr   <= '0;
              r_loop_cnt <= r_loop_cnt + 16'd1;
`else
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state  <= RUN;
            r_rd_ptr <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  instr_loader_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_load_wr && !clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign issue_valid = r_valid;
  assign issue_instr = w_rdata;
  assign count       = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign overflow    = r_ovf;
`ifdef INSTR_LOADER_LOOP_EN
  assign loop_cnt    = r_loop_cnt;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a queue-based program model.
// Inputs change on the falling edge; outputs are sampled on the falling edge before driving.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int D  = DEF_DEPTH;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [W-1:0]  issue_instr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef INSTR_LOADER_LOOP_EN
  logic [15:0]   loop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: the program as the host sees it, plus the sticky overflow flag.
  logic [W-1:0] prog[$];
  logic         m_ovf = 1'b0;

  always #5 clk = ~clk;

  instr_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .start       (start),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_instr (issue_instr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
`ifdef INSTR_LOADER_LOOP_EN
    ,
    .loop_cnt    (loop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [W-1:0] d);
    if (prog.size() < D) prog.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    prog.delete();
    m_ovf = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    model_write(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_loaded(input string tag);
    check({tag, "_count"}, 64'(count), 64'(prog.size()));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  // Issues the modelled program and checks every presented instruction and the final done.
  task automatic run_prog(input string tag, input bit do_start, input int pct, input int stall,
                          output int n_cyc);
    int idx = 0;
    int cyc = 0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (done !== 1'b1 && cyc < 400) begin
      issue_ready = (cyc >= stall) && ($urandom_range(99) < pct);
      check({tag, "_valid"}, 64'(issue_valid), 64'(1));
      if (idx < prog.size()) begin
        check({tag, "_instr"}, 64'(issue_instr), 64'(prog[idx]));
      end else begin
        check({tag, "_extra"}, 64'(idx), 64'(prog.size()));
        break;
      end
      if (issue_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    issue_ready = 1'b0;
    check({tag, "_issued"}, 64'(idx), 64'(prog.size()));
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_validoff"}, 64'(issue_valid), 64'(0));
    n_cyc = cyc;
  endtask

  initial begin
    int ncyc;
    int ncyc2;
    int n;

    #12;
    @(negedge clk);
    check("rst_valid", 64'(issue_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_instr", 64'(issue_instr), 64'(0));
    check_loaded("rst");
    rst = 1'b0;
    @(negedge clk);

`ifndef INSTR_LOADER_LOOP_EN
    // Two-instruction program at full rate
    load(32'h00020820);
    load(32'h00844022);
    check_loaded("basic");
    run_prog("basic", 1'b1, 100, 0, ncyc);
    check("basic_cycles", 64'(ncyc), 64'(2));

    // Replay from DONE with the core stalling for three cycles
    run_prog("stall", 1'b1, 100, 3, ncyc);
    check("stall_cycles", 64'(ncyc), 64'(5));

    // Overflow: the 17th write is dropped
    do_clear();
    for (int i = 0; i < D + 1; i++) load($urandom);
    check_loaded("ovf");
    run_prog("ovf", 1'b1, 100, 0, ncyc);
    check("ovf_cycles", 64'(ncyc), 64'(D));

    // Writes are ignored in DONE
    load(32'hDEAD_BEEF);
    check("done_wr_count", 64'(count), 64'(D));
    void'(prog.pop_back());
    prog.push_back(prog[D-1]);
    void'(prog.pop_back());

    // Clear mid-run after one accept, then a start with an empty buffer is ignored
    do_clear();
    load(32'h11111111);
    load(32'h22222222);
    load(32'h33333333);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue_ready = 1'b1;
    check("clr_first", 64'(issue_instr), 64'(32'h11111111));
    @(negedge clk);
    issue_ready = 1'b0;
    check("clr_second", 64'(issue_instr), 64'(32'h22222222));
    do_clear();
    check("clr_count", 64'(count), 64'(0));
    check("clr_valid", 64'(issue_valid), 64'(0));
    check("clr_busy", 64'(busy), 64'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_start_busy", 64'(busy), 64'(0));
    check("clr_start_valid", 64'(issue_valid), 64'(0));

    // Start together with a write: the write joins the run; then replay
    load(32'hAAAA0001);
    wr_en = 1'b1;
    wr_data = 32'hAAAA0002;
    start = 1'b1;
    model_write(32'hAAAA0002);
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    check_loaded("sw");
    run_prog("sw", 1'b0, 100, 0, ncyc);
    run_prog("sw_replay", 1'b1, 100, 0, ncyc2);
    check("sw_replay_cycles", 64'(ncyc2), 64'(ncyc));

    // Randomized programs with random backpressure
    for (int it = 0; it < 8; it++) begin
      do_clear();
      n = $urandom_range(1, D + 2);
      for (int i = 0; i < n; i++) begin
        load($urandom);
        if ($urandom_range(3) == 0) @(negedge clk);
      end
      check_loaded("rnd");
      run_prog("rnd", 1'b1, 60, 0, ncyc);
    end
`else
    // Looping: 3-instruction program, 7 accepts gives two wraps
    do_clear();
    load(32'h0000_0A01);
    load(32'h0000_0A02);
    load(32'h0000_0A03);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue_ready = 1'b1;
      check("loop_instr", 64'(issue_instr), 64'(prog[i % 3]));
      @(negedge clk);
    end
    issue_ready = 1'b0;
    check("loop_cnt", 64'(loop_cnt), 64'(2));
    check("loop_busy", 64'(busy), 64'(1));
    check("loop_done", 64'(done), 64'(0));
    check("loop_next", 64'(issue_instr), 64'(prog[7 % 3]));
    do_clear();
    check("loop_clr_cnt", 64'(loop_cnt), 64'(0));
    check("loop_clr_busy", 64'(busy), 64'(0));
`endif

    // Asynchronous reset mid-run, between clock edges, with overflow set
    do_clear();
    for (int i = 0; i < D + 1; i++) load($urandom);
    check_loaded("arst");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arst_busy_pre", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(issue_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_instr", 64'(issue_instr), 64'(0));
    prog.delete();
    m_ovf = 1'b0;
    check_loaded("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Parametrised program-load buffer between the bench/host side and the cpu core.
- Host writes instructions one per strobe into an internal buffer.
- On start, the block replays them in order to the core over a valid/ready issue handshake, then reports done.
- Supersedes the fixed single-register next_instruction/mem_write loading path. Adds configurable depth and width, an occupancy count, overflow detection, abort, and re-run.

Parameters:
- WIDTH, 32, instruction width in bits
- DEPTH, 16, buffer entries; must be a power of two, at least 2
- CW, $clog2(DEPTH+1), width of the count output

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  load strobe; one instruction per cycle high
- wr_data  in  WIDTH  instruction to load
- start  in  1  begin issuing the loaded program
- clear  in  1  synchronous abort; empties the buffer
- issue_valid  out  1  issue_instr is valid
- issue_ready  in  1  core accepts issue_instr
- issue_instr  out  WIDTH  current instruction
- count  out  CW  number of loaded instructions
- busy  out  1  state is RUN
- done  out  1  program fully issued
- overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (asynchronous):
  - state=LOAD; count=0, wr_ptr=0, rd_ptr=0.
  - issue_valid=0, busy=0, done=0, overflow=0; issue_instr reads 0.
  - Buffer contents are don't-care.
- States: LOAD, RUN, DONE.
- Priority each cycle: clear > start > wr_en.
  - clear in any state → LOAD; count=0, wr_ptr=0, rd_ptr=0; done=0; overflow=0.
- LOAD:
  - wr_en with count<DEPTH: mem[wr_ptr]<=wr_data; wr_ptr++; count++.
  - wr_en with count==DEPTH: write dropped; overflow<=1.
  - start with count>0 → RUN, rd_ptr=0. A wr_en in the same cycle is accepted first and included in the run.
  - start with count==0 (and no same-cycle write): ignored; remain in LOAD.
- RUN:
  - issue_valid=1, busy=1.
  - issue_instr=mem[rd_ptr], combinational read, zero added latency.
  - issue_instr and issue_valid hold stable until issue_ready.
  - On valid&&ready: if rd_ptr==count-1 → DONE, else rd_ptr++.
  - wr_en and start are ignored in RUN; count is unchanged.
  - issue_ready held high gives one instruction per cycle; a program of N instructions completes in N cycles.
- DONE:
  - done=1, issue_valid=0.
  - start → RUN with rd_ptr=0, replaying the same program; done clears on that edge.
  - wr_en is ignored; the host must clear before loading a new program.
- Pointers are log2(DEPTH) bits. wr_ptr wraps to 0 on the DEPTH-th write, but count saturates at DEPTH, so no entry is overwritten.
- issue_instr outside RUN drives mem[rd_ptr]; consumers qualify it with issue_valid.

Optional Feature:
- Macro: INSTR_LOADER_LOOP_EN.
- Defined:
  - On acceptance of the last instruction in RUN, rd_ptr wraps to 0 and the block stays in RUN, issuing continuously.
  - Only clear ends the loop; it returns to LOAD.
  - DONE is unreachable and done stays 0.
  - Adds output loop_cnt [15:0]: increments on each wrap, wraps at 0xFFFF→0, reset 0, zeroed by clear.
- Undefined: behaviour as above; no loop_cnt port.

Decomposition:
- Shared package instr_loader_pkg holds:
  - state encoding: LOAD=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH/DEPTH constants, reused by the cpu fetch stage.
- One natural sub-module: instr_loader_mem, a DEPTH×WIDTH register array with a synchronous write port and a combinational read port.
- FSM, pointers and flags live in the top module.

Test Plan:
- Load 0x00020820, then 0x00844022; start, issue_ready=1 → count=2; issue_instr 0x00020820 then 0x00844022 on consecutive cycles; done=1 on the third cycle.
- Same program with issue_ready low for 3 cycles at the start of RUN → issue_instr holds 0x00020820 and issue_valid stays 1; issue proceeds when ready rises.
- 17 writes at DEPTH=16 → count=16, overflow=1; the run issues exactly 16 instructions, the 17th value never appears.
- Assert clear mid-RUN after 1 of 3 instructions accepted → next cycle state LOAD, count=0, issue_valid=0; a later start is ignored.
- Assert start with wr_en in the same cycle, count=1 → run issues 2 instructions. From DONE, start again → identical sequence replayed.
- Assert rst asynchronously mid-RUN, between clock edges → outputs zero immediately. With INSTR_LOADER_LOOP_EN defined, a 3-instruction program with 7 accepts → loop_cnt=2 and issuing continues.
